// File: rtl/exhaust_mode_scheduler_pkg.sv
// rtl/exhaust_mode_scheduler_pkg.sv - shared mode codes, fan codes and helpers for the hood scheduler
// Contents:
//   MODE_WIDTH    width of the mode code bus
//   mode_e        mode codes driven on current_mode
//   FAN_*         fan speed codes driven to the motor driver
//   req_e         arbitration winner of the request inputs
//   fan_for_mode  fan speed for a mode
//   is_timed_mode modes that run the seconds countdown
package exhaust_mode_scheduler_pkg;

  localparam int MODE_WIDTH = 3;

  typedef enum logic [MODE_WIDTH-1:0] {
    OFF_MODE       = 3'd0,
    STANDBY_MODE   = 3'd1,
    FIRST_MODE     = 3'd2,
    SECOND_MODE    = 3'd3,
    THIRD_MODE     = 3'd4,
    CLEAN_MODE     = 3'd5,
    EXIT_WAIT_MODE = 3'd6
  } mode_e;

  localparam logic [1:0] FAN_OFF  = 2'd0;
  localparam logic [1:0] FAN_LOW  = 2'd1;
  localparam logic [1:0] FAN_MID  = 2'd2;
  localparam logic [1:0] FAN_HIGH = 2'd3;

  typedef enum logic [2:0] {
    REQ_NONE    = 3'd0,
    REQ_POWER   = 3'd1,
    REQ_STANDBY = 3'd2,
    REQ_CLEAN   = 3'd3,
    REQ_THIRD   = 3'd4,
    REQ_SECOND  = 3'd5,
    REQ_FIRST   = 3'd6
  } req_e;

  function automatic logic [1:0] fan_for_mode(input mode_e m);
    case (m)
      FIRST_MODE, CLEAN_MODE:     return FAN_LOW;
      SECOND_MODE:                return FAN_MID;
      THIRD_MODE, EXIT_WAIT_MODE: return FAN_HIGH;
      default:                    return FAN_OFF;
    endcase
  endfunction

  function automatic logic is_timed_mode(input mode_e m);
    return (m == THIRD_MODE) || (m == CLEAN_MODE) || (m == EXIT_WAIT_MODE);
  endfunction

endpackage

// File: rtl/exhaust_mode_scheduler_mode_second_timer.sv
// rtl/exhaust_mode_scheduler_mode_second_timer.sv - prescaler plus seconds down-counter for timed modes
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   load           restart: clear prescaler, load remaining with load_value
//   load_value     seconds to count down from
//   enable         count while high; prescaler and remaining held at 0 while low
//   remaining      seconds left in the current timed mode
//   expire         high in the last cycle of the countdown (remaining = 1, prescaler wrapping)
module mode_second_timer #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       enable,
  output logic [7:0] remaining,
  output logic       expire
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] prescaler;
  logic          wrap;

  assign wrap = (prescaler == PRESC_MAX);
  // Not gated by enable: outside timed modes remaining is 0, so this cannot fire.
  assign expire = wrap && (remaining == 8'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prescaler <= '0;
      remaining <= '0;
    end else if (load) begin
      prescaler <= '0;
      remaining <= load_value;
    end else if (!enable) begin
      prescaler <= '0;
      remaining <= '0;
    end else if (wrap) begin
      prescaler <= '0;
      if (remaining != 8'd0) remaining <= remaining - 8'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

endmodule

// File: rtl/exhaust_mode_scheduler.sv
// rtl/exhaust_mode_scheduler.sv - hood mode state machine with request arbitration and timed modes
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   power_req       power-toggle pulse
//   req_first       request first mode
//   req_second      request second mode
//   req_third       request hurricane mode (once per power-on)
//   req_clean       request self-clean
//   req_standby     request return to standby
//   current_mode    registered mode code
//   remaining_secs  countdown of timed modes, 0 otherwise
//   fan_speed       0 off, 1 low, 2 mid, 3 high
//   third_locked    hurricane already used since power-on
//   clean_done      one-cycle pulse when self-clean completes
module exhaust_mode_scheduler
  import exhaust_mode_scheduler_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int THIRD_SECS    = 60,
  parameter int EXIT_SECS     = 60,
  parameter int CLEAN_SECS    = 180
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  power_req,
  input  logic                  req_first,
  input  logic                  req_second,
  input  logic                  req_third,
  input  logic                  req_clean,
  input  logic                  req_standby,
  output logic [MODE_WIDTH-1:0] current_mode,
  output logic [7:0]            remaining_secs,
  output logic [1:0]            fan_speed,
  output logic                  third_locked,
  output logic                  clean_done
);

  mode_e      mode, next_mode;
  req_e       winner;
  logic       next_locked;
  logic       next_clean_done;
  logic       timer_load;
  logic [7:0] timer_value;
  logic       timer_enable;
  logic       expire;

  assign current_mode = mode;

  // Only the highest-priority request is evaluated; an illegal winner is not
  // replaced by a lower-priority request.
  always_comb begin
    winner = REQ_NONE;
    if      (power_req)   winner = REQ_POWER;
    else if (req_standby) winner = REQ_STANDBY;
    else if (req_clean)   winner = REQ_CLEAN;
    else if (req_third)   winner = REQ_THIRD;
    else if (req_second)  winner = REQ_SECOND;
    else if (req_first)   winner = REQ_FIRST;
  end

  always_comb begin
    next_mode       = mode;
    next_locked     = third_locked;
    next_clean_done = 1'b0;
    timer_load      = 1'b0;
    timer_value     = 8'd0;
    case (mode)
      OFF_MODE: begin
        if (winner == REQ_POWER) next_mode = STANDBY_MODE;
      end
      STANDBY_MODE: begin
        case (winner)
          REQ_POWER:  next_mode = OFF_MODE;
          REQ_FIRST:  next_mode = FIRST_MODE;
          REQ_SECOND: next_mode = SECOND_MODE;
          REQ_THIRD: begin
            if (!third_locked) begin
              next_mode   = THIRD_MODE;
              next_locked = 1'b1;
              timer_load  = 1'b1;
              timer_value = 8'(THIRD_SECS);
            end
          end
          REQ_CLEAN: begin
            next_mode   = CLEAN_MODE;
            timer_load  = 1'b1;
            timer_value = 8'(CLEAN_SECS);
          end
          default: ;
        endcase
      end
      FIRST_MODE: begin
        case (winner)
          REQ_POWER:   next_mode = OFF_MODE;
          REQ_STANDBY: next_mode = STANDBY_MODE;
          REQ_SECOND:  next_mode = SECOND_MODE;
          default: ;
        endcase
      end
      SECOND_MODE: begin
        case (winner)
          REQ_POWER:   next_mode = OFF_MODE;
          REQ_STANDBY: next_mode = STANDBY_MODE;
          REQ_FIRST:   next_mode = FIRST_MODE;
          default: ;
        endcase
      end
      // In timed modes an accepted request takes precedence over expiry.
      THIRD_MODE: begin
        if (winner == REQ_POWER) begin
          next_mode = OFF_MODE;
        end else if (winner == REQ_STANDBY) begin
          next_mode   = EXIT_WAIT_MODE;
          timer_load  = 1'b1;
          timer_value = 8'(EXIT_SECS);
        end else if (expire) begin
          next_mode = SECOND_MODE;
        end
      end
      EXIT_WAIT_MODE: begin
        if (winner == REQ_POWER) next_mode = OFF_MODE;
        else if (expire)         next_mode = STANDBY_MODE;
      end
      CLEAN_MODE: begin
        if (winner == REQ_POWER) begin
          next_mode = OFF_MODE;
        end else if (expire) begin
          next_mode       = STANDBY_MODE;
          next_clean_done = 1'b1;
        end
      end
      default: next_mode = OFF_MODE;
    endcase
    if (next_mode == OFF_MODE) next_locked = 1'b0;
  end

  // Leaving a timed mode drops enable so remaining returns to 0 on the same edge.
  assign timer_enable = is_timed_mode(next_mode);

  mode_second_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .load      (timer_load),
    .load_value(timer_value),
    .enable    (timer_enable),
    .remaining (remaining_secs),
    .expire    (expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode         <= OFF_MODE;
      fan_speed    <= FAN_OFF;
      third_locked <= 1'b0;
      clean_done   <= 1'b0;
    end else begin
      mode         <= next_mode;
      fan_speed    <= fan_for_mode(next_mode);
      third_locked <= next_locked;
      clean_done   <= next_clean_done;
    end
  end

endmodule

// File: tb/tb_exhaust_mode_scheduler.sv
// tb/tb_exhaust_mode_scheduler.sv - scoreboard bench for exhaust_mode_scheduler
module tb_exhaust_mode_scheduler;

  localparam int T  = 4;
  localparam int S3 = 3;
  localparam int SX = 2;
  localparam int SC = 5;

  // request vector bits
  localparam logic [5:0] RP = 6'b100000; // power
  localparam logic [5:0] RB = 6'b010000; // standby
  localparam logic [5:0] RC = 6'b001000; // clean
  localparam logic [5:0] RT = 6'b000100; // third
  localparam logic [5:0] RS = 6'b000010; // second
  localparam logic [5:0] RF = 6'b000001; // first
  localparam logic [5:0] R0 = 6'b000000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       power_req = 1'b0, req_first = 1'b0, req_second = 1'b0;
  logic       req_third = 1'b0, req_clean = 1'b0, req_standby = 1'b0;
  logic [2:0] current_mode;
  logic [7:0] remaining_secs;
  logic [1:0] fan_speed;
  logic       third_locked;
  logic       clean_done;

  exhaust_mode_scheduler #(
    .TICKS_PER_SEC(T), .THIRD_SECS(S3), .EXIT_SECS(SX), .CLEAN_SECS(SC)
  ) dut (
    .clk(clk), .rstn(rstn),
    .power_req(power_req), .req_first(req_first), .req_second(req_second),
    .req_third(req_third), .req_clean(req_clean), .req_standby(req_standby),
    .current_mode(current_mode), .remaining_secs(remaining_secs),
    .fan_speed(fan_speed), .third_locked(third_locked), .clean_done(clean_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int rem;
    int fan;
    int lock;
    int done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: mode names 0 OFF,1 STANDBY,2 FIRST,3 SECOND,4 THIRD,5 CLEAN,6 EXIT_WAIT.
  // Timed modes are tracked as elapsed cycles against a total duration of secs*T.
  int m_mode = 0, m_elapsed = 0, m_lock = 0, m_done = 0;

  function automatic int secs_of(input int md);
    case (md)
      4: return S3;
      6: return SX;
      5: return SC;
      default: return 0;
    endcase
  endfunction

  function automatic int fan_of(input int md);
    case (md)
      2, 5: return 1;
      3: return 2;
      4, 6: return 3;
      default: return 0;
    endcase
  endfunction

  // Legal target for the winning request, -1 if the winner is not accepted.
  function automatic int target_of(input int md, input int lock, input logic [5:0] r);
    logic [5:0] w;
    w = 6'b0;
    for (int b = 5; b >= 0; b--) if (r[b]) begin w[b] = 1'b1; break; end
    case (md)
      0: if (w == RP) return 1;
      1: begin
        if (w == RP) return 0;
        if (w == RF) return 2;
        if (w == RS) return 3;
        if (w == RT && lock == 0) return 4;
        if (w == RC) return 5;
      end
      2: begin
        if (w == RS) return 3;
        if (w == RB) return 1;
        if (w == RP) return 0;
      end
      3: begin
        if (w == RF) return 2;
        if (w == RB) return 1;
        if (w == RP) return 0;
      end
      4: begin
        if (w == RB) return 6;
        if (w == RP) return 0;
      end
      5, 6: if (w == RP) return 0;
      default: ;
    endcase
    return -1;
  endfunction

  task automatic model_cycle(input logic [5:0] r);
    int tgt;
    tgt = target_of(m_mode, m_lock, r);
    m_done = 0;
    if (tgt >= 0) begin
      m_mode = tgt;
      m_elapsed = 0;
      if (tgt == 4) m_lock = 1;
      if (tgt == 0) m_lock = 0;
    end else if (secs_of(m_mode) > 0) begin
      m_elapsed++;
      if (m_elapsed == secs_of(m_mode) * T) begin
        if (m_mode == 5) m_done = 1;
        m_mode = (m_mode == 4) ? 3 : 1;
        m_elapsed = 0;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.mode = m_mode;
    e.rem  = (secs_of(m_mode) > 0) ? secs_of(m_mode) - m_elapsed / T : 0;
    e.fan  = fan_of(m_mode);
    e.lock = m_lock;
    e.done = m_done;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus: drive at negedge, predict the post-edge outputs.
  task automatic apply(input logic [5:0] r, input logic rst_low);
    @(negedge clk);
    {power_req, req_standby, req_clean, req_third, req_second, req_first} = r;
    if (rst_low) begin
      rstn = 1'b0;
      m_mode = 0; m_elapsed = 0; m_lock = 0; m_done = 0;
      #1;
      check("async_reset_mode", int'(current_mode), 0);
      check("async_reset_rem", int'(remaining_secs), 0);
      check("async_reset_lock", int'(third_locked), 0);
    end else begin
      rstn = 1'b1;
      model_cycle(r);
    end
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(R0, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle; compare 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("current_mode", int'(current_mode), e.mode);
        check("remaining_secs", int'(remaining_secs), e.rem);
        check("fan_speed", int'(fan_speed), e.fan);
        check("third_locked", int'(third_locked), e.lock);
        check("clean_done", int'(clean_done), e.done);
      end
    end
  end

  initial begin
    logic [5:0] r;
    apply(R0, 1'b1);
    apply(R0, 1'b1);
    // hurricane entry and timed drop to SECOND
    apply(RP, 1'b0);
    apply(RT, 1'b0);
    idle(14);
    // hurricane locked until power cycle
    apply(RB, 1'b0);
    apply(RT, 1'b0);
    apply(RP, 1'b0);
    apply(RP, 1'b0);
    apply(RT, 1'b0);
    // exit wait, with an ignored request
    apply(RB, 1'b0);
    apply(RF, 1'b0);
    idle(9);
    // self-clean completion, then aborted by power
    apply(RC, 1'b0);
    idle(22);
    apply(RC, 1'b0);
    idle(9);
    apply(RP, 1'b0);
    apply(RP, 1'b0);
    // simultaneous requests
    apply(RF | RT | RC, 1'b0);
    apply(RP, 1'b0);
    apply(RP, 1'b0);
    apply(RF, 1'b0);
    apply(RP | RS, 1'b0);
    apply(RP, 1'b0);
    // reset mid-countdown in hurricane
    apply(RT, 1'b0);
    idle(4);
    apply(R0, 1'b1);
    apply(RP, 1'b0);
    apply(RT, 1'b0);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r = R0;
      r[5] = ($urandom_range(0, 39) == 0);
      for (int b = 0; b < 5; b++) r[b] = ($urandom_range(0, 11) == 0);
      apply(r, $urandom_range(0, 699) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
